// File: rtl/uart_host_master_if.sv
// rtl/uart_host_master_if.sv - host-side register bus of the UART device
// Purpose: carries the one-cycle register accesses between the host master and the UART.
// Signals:
//   ce      - chip enable, one cycle per access
//   we      - 1 = write, 0 = read
//   adr     - register address
//   dat_o   - write data from the master
//   dat_oe  - master drives dat (write cycles only)
//   slv_dat - read data from the device
//   slv_oe  - device drives dat (read cycles only)
//   dat     - shared bidirectional data bus, resolved here from both drivers
interface uart_host_master_if;
    logic       ce;
    logic       we;
    logic [1:0] adr;
    logic [7:0] dat_o;
    logic       dat_oe;
    logic [7:0] slv_dat;
    logic       slv_oe;
    wire  [7:0] dat;

    assign dat = dat_oe ? dat_o   : 8'bz;
    assign dat = slv_oe ? slv_dat : 8'bz;

    modport master (output ce, we, adr, dat_o, dat_oe, input dat);
    modport slave  (input ce, we, adr, dat, output slv_dat, slv_oe);
endinterface

// File: rtl/uart_host_master.sv
// rtl/uart_host_master.sv - CPU-less host bus master for the 4-register UART
// Purpose: programs divisor and control after reset (or on cfg_req), then polls the
// status register, moving received bytes to the rx stream and tx stream bytes to the
// UART transmit buffer.
// Ports:
//   clk, arst          - clock, asynchronous active-high reset
//   bus                - register bus (master side)
//   inter              - UART interrupt, shortens the poll wait
//   tx_data/valid/ready- byte stream into the UART, tx_ready pulses on acceptance
//   rx_data/valid/ready- byte stream out of the UART, held until accepted
//   err                - {overrun, framing, parity} pulse after a status read
//   cfg_req, cfg_done  - reprogram request, configuration complete flag
module uart_host_master #(
    parameter logic [15:0] BR_DIV      = 16'd26,
    parameter logic        PARITY_EN   = 1'b0,
    parameter logic        PARITY_EVEN = 1'b0,
    parameter logic        ERR_INT_EN  = 1'b1,
    parameter int unsigned POLL_GAP    = 8
) (
    input  logic                      clk,
    input  logic                      arst,
    uart_host_master_if.master        bus,
    input  logic                      inter,
    input  logic [7:0]                tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic [7:0]                rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic [2:0]                err,
    input  logic                      cfg_req,
    output logic                      cfg_done
);

    typedef enum logic [2:0] {
        S_CFG_LS,
        S_CFG_MS,
        S_CFG_CTRL,
        S_GAP,
        S_WAIT,
        S_RD_STAT,
        S_RD_RX,
        S_WR_TX
    } state_t;

    localparam logic [7:0] GAP_LOAD  = 8'(POLL_GAP - 1);
    localparam logic [7:0] CTRL_BYTE = {3'b000, PARITY_EVEN, PARITY_EN, ERR_INT_EN, 2'b00};

    localparam logic [1:0] ADR_DATA = 2'd0;
    localparam logic [1:0] ADR_STAT = 2'd1;
    localparam logic [1:0] ADR_DIVL = 2'd2;
    localparam logic [1:0] ADR_DIVM = 2'd3;

    state_t     state_q, state_d;
    state_t     after_gap_q, after_gap_d;   // access to perform once the idle cycle is over
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic [2:0] err_q, err_d;
    logic       cfg_done_q, cfg_done_d;

    logic       ce_c;
    logic       we_c;
    logic [1:0] adr_c;
    logic [7:0] dat_c;
    logic       tx_ready_c;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= S_CFG_LS;
            after_gap_q <= S_CFG_MS;
            cnt_q       <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            err_q       <= '0;
            cfg_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            after_gap_q <= after_gap_d;
            cnt_q       <= cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            err_q       <= err_d;
            cfg_done_q  <= cfg_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        after_gap_d = after_gap_q;
        // The poll counter is reloaded everywhere except WAIT, so every entry
        // into WAIT starts a full poll period.
        cnt_d       = (state_q == S_WAIT) ? cnt_q : GAP_LOAD;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q & ~rx_ready;
        err_d       = 3'b000;
        cfg_done_d  = cfg_done_q;
        ce_c        = 1'b0;
        we_c        = 1'b0;
        adr_c       = ADR_DATA;
        dat_c       = 8'h00;
        tx_ready_c  = 1'b0;

        unique case (state_q)
            S_CFG_LS: begin
                ce_c        = 1'b1;
                we_c        = 1'b1;
                adr_c       = ADR_DIVL;
                dat_c       = BR_DIV[7:0];
                after_gap_d = S_CFG_MS;
                state_d     = S_GAP;
            end
            S_CFG_MS: begin
                ce_c        = 1'b1;
                we_c        = 1'b1;
                adr_c       = ADR_DIVM;
                dat_c       = BR_DIV[15:8];
                after_gap_d = S_CFG_CTRL;
                state_d     = S_GAP;
            end
            S_CFG_CTRL: begin
                ce_c        = 1'b1;
                we_c        = 1'b1;
                adr_c       = ADR_STAT;
                dat_c       = CTRL_BYTE;
                cfg_done_d  = 1'b1;
                after_gap_d = S_WAIT;
                state_d     = S_GAP;
            end
            S_GAP: begin
                state_d = after_gap_q;
            end
            S_WAIT: begin
                // Reconfiguration outranks an interrupt-triggered poll.
                if (cfg_req) begin
                    cfg_done_d = 1'b0;
                    state_d    = S_CFG_LS;
                end else if (inter || cnt_q == 8'd0) begin
                    state_d = S_RD_STAT;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_RD_STAT: begin
                ce_c  = 1'b1;
                adr_c = ADR_STAT;
                err_d = bus.dat[3:1];
                // A stalled consumer leaves the byte in the UART; transmit is
                // considered instead so tx traffic keeps flowing.
                if (bus.dat[0] && !rx_valid_q) begin
                    after_gap_d = S_RD_RX;
                    state_d     = S_GAP;
                end else if (tx_valid && !bus.dat[5]) begin
                    after_gap_d = S_WR_TX;
                    state_d     = S_GAP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RD_RX: begin
                ce_c       = 1'b1;
                adr_c      = ADR_DATA;
                rx_data_d  = bus.dat;
                rx_valid_d = 1'b1;
                state_d    = S_WAIT;
            end
            S_WR_TX: begin
                // The producer may have withdrawn the byte during the gap cycle.
                if (tx_valid) begin
                    ce_c       = 1'b1;
                    we_c       = 1'b1;
                    adr_c      = ADR_DATA;
                    dat_c      = tx_data;
                    tx_ready_c = 1'b1;
                end
                state_d = S_WAIT;
            end
            default: begin
                state_d = S_CFG_LS;
            end
        endcase
    end

    // Bus strobes are gated by reset so an access in flight is dropped at once.
    assign bus.ce     = ce_c & ~arst;
    assign bus.we     = we_c & ~arst;
    assign bus.adr    = arst ? ADR_DATA : adr_c;
    assign bus.dat_o  = dat_c;
    assign bus.dat_oe = ce_c & we_c & ~arst;

    assign tx_ready = tx_ready_c & ~arst;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign err      = err_q;
    assign cfg_done = cfg_done_q;

endmodule

// File: tb/tb_uart_host_master.sv
// tb/tb_uart_host_master.sv - scoreboard bench for uart_host_master
module tb_uart_host_master;
    localparam logic [15:0] BR_DIV      = 16'd26;
    localparam logic        PARITY_EN   = 1'b0;
    localparam logic        PARITY_EVEN = 1'b0;
    localparam logic        ERR_INT_EN  = 1'b1;
    localparam int          POLL_GAP    = 8;
    localparam logic [7:0]  CTRL_EXP    = 8'(4 * int'(ERR_INT_EN) + 8 * int'(PARITY_EN) + 16 * int'(PARITY_EVEN));

    logic       clk = 1'b0;
    logic       arst;
    logic       inter;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [2:0] err;
    logic       cfg_req;
    logic       cfg_done;

    uart_host_master_if bus ();

    uart_host_master #(
        .BR_DIV(BR_DIV), .PARITY_EN(PARITY_EN), .PARITY_EVEN(PARITY_EVEN),
        .ERR_INT_EN(ERR_INT_EN), .POLL_GAP(POLL_GAP)
    ) dut (
        .clk(clk), .arst(arst), .bus(bus), .inter(inter),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .err(err), .cfg_req(cfg_req), .cfg_done(cfg_done)
    );

    always #5 clk = ~clk;

    // UART device model: status = {0, 0, tx_busy, 0, ovr, frm, par, rx_avail}
    logic       rx_avail;
    logic       tx_busy;
    logic [2:0] err_bits;
    logic [7:0] rx_buf;
    assign bus.slv_oe  = bus.ce & ~bus.we;
    assign bus.slv_dat = (bus.adr == 2'd1) ? {2'b00, tx_busy, 1'b0, err_bits, rx_avail} : rx_buf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_stat_cnt = 0, rd_rx_cnt = 0, wr_tx_cnt = 0, rx_hs_cnt = 0, tx_rdy_cnt = 0, err_pulse_cnt = 0;
    bit mon_en = 1'b0;
    logic prev_ce = 1'b0;
    bit   sink_rand = 1'b0;
    logic sink_level = 1'b1;

    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];
    int         exp_err_cyc[$];
    logic [2:0] exp_err_val[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every observed DUT output against the scoreboard queues.
    initial begin
        logic wr0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en && !arst) begin
                while (exp_err_cyc.size() > 0 && exp_err_cyc[0] < cyc) begin
                    chk("err_missing", 3'b000, {29'd0, exp_err_val[0]});
                    void'(exp_err_cyc.pop_front());
                    void'(exp_err_val.pop_front());
                end
                if (exp_err_cyc.size() > 0 && exp_err_cyc[0] == cyc) begin
                    chk("err_pulse", err, exp_err_val[0]);
                    void'(exp_err_cyc.pop_front());
                    void'(exp_err_val.pop_front());
                end else if (err != 3'b000) begin
                    chk("err_unexpected", err, 0);
                end
                if (err != 3'b000) err_pulse_cnt++;

                wr0 = bus.ce && bus.we && bus.adr == 2'd0;
                if (wr0 || tx_ready) chk("tx_ready_vs_write", tx_ready, wr0);
                if (tx_ready) tx_rdy_cnt++;

                if (bus.ce) begin
                    chk("ce_gap", prev_ce, 0);
                    if (!bus.we && bus.adr == 2'd1) begin
                        rd_stat_cnt++;
                        if (err_bits != 3'b000) begin
                            exp_err_cyc.push_back(cyc + 1);
                            exp_err_val.push_back(err_bits);
                        end
                    end else if (!bus.we && bus.adr == 2'd0) begin
                        rd_rx_cnt++;
                        chk("rx_read_while_full", rx_valid, 0);
                        chk("rx_read_avail", rx_avail, 1);
                    end else if (wr0) begin
                        wr_tx_cnt++;
                        chk("tx_write_busy", tx_busy, 0);
                        chk("tx_write_expected", exp_tx.size() > 0, 1);
                        if (exp_tx.size() > 0) chk("tx_data", bus.dat, exp_tx.pop_front());
                    end
                end

                if (rx_valid && rx_ready) begin
                    rx_hs_cnt++;
                    chk("rx_expected", exp_rx.size() > 0, 1);
                    if (exp_rx.size() > 0) chk("rx_data", rx_data, exp_rx.pop_front());
                end
            end
            prev_ce = bus.ce;
        end
    end

    // rx consumer: fixed level or random back-pressure
    initial begin
        rx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rx_ready = sink_rand ? 1'($urandom_range(0, 1)) : sink_level;
        end
    end

    function automatic int cnt_of(input int sel);
        case (sel)
            0: return rd_stat_cnt;
            1: return rd_rx_cnt;
            2: return wr_tx_cnt;
            default: return rx_hs_cnt;
        endcase
    endfunction

    task automatic wait_cnt(input int sel, input int target, input int budget, input string name);
        int n = 0;
        while (cnt_of(sel) < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (cnt_of(sel) < target) begin
            errors++;
            $display("FAIL %s: timeout, count %0d required %0d", name, cnt_of(sel), target);
        end
    endtask

    // Configuration sequence starting at the next bus access.
    task automatic cfg_seq(input string tag);
        logic [1:0] ea[3];
        logic [7:0] ed[3];
        int n = 0;
        ea[0] = 2'd2; ea[1] = 2'd3; ea[2] = 2'd1;
        ed[0] = BR_DIV[7:0]; ed[1] = BR_DIV[15:8]; ed[2] = CTRL_EXP;
        @(negedge clk);
        while (!bus.ce && n < 30) begin
            @(negedge clk);
            n++;
        end
        for (int k = 1; k <= 7; k++) begin
            if (k > 1) @(negedge clk);
            if (k <= 6) chk({tag, "_ce"}, bus.ce, k % 2);
            if (k % 2 == 1 && k <= 5) begin
                chk({tag, "_we"}, bus.we, 1);
                chk({tag, "_adr"}, bus.adr, ea[k / 2]);
                chk({tag, "_dat"}, bus.dat, ed[k / 2]);
            end
            if (k % 2 == 0 && k <= 6) chk({tag, "_dat_oe"}, bus.dat_oe, 0);
            if (k <= 5) chk({tag, "_cfg_done_low"}, cfg_done, 0);
            if (k == 7) chk({tag, "_cfg_done_high"}, cfg_done, 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, w0, r0, h0, ep, t0, lat;
        bit seen;
        logic [7:0] b;
        arst = 1'b1; inter = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; cfg_req = 1'b0;
        rx_avail = 1'b0; tx_busy = 1'b0; err_bits = 3'b000; rx_buf = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ce", bus.ce, 0);
        chk("rst_we", bus.we, 0);
        chk("rst_adr", bus.adr, 0);
        chk("rst_dat_oe", bus.dat_oe, 0);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_err", err, 0);
        chk("rst_cfg_done", cfg_done, 0);

        @(posedge clk); #1 arst = 1'b0;
        mon_en = 1'b1;
        cfg_seq("cfg");

        // single received byte
        rx_buf = 8'hA5; exp_rx.push_back(8'hA5); rx_avail = 1'b1;
        wait_cnt(1, rd_rx_cnt + 1, 100, "rx_read_a5");
        rx_avail = 1'b0;
        wait_cnt(3, rx_hs_cnt + 1, 50, "rx_hs_a5");
        chk("rx_valid_one_cycle", rx_valid, 0);

        // single transmitted byte
        t0 = tx_rdy_cnt;
        tx_data = 8'h3C; tx_valid = 1'b1; exp_tx.push_back(8'h3C);
        wait_cnt(2, wr_tx_cnt + 1, 100, "tx_write_3c");
        tx_valid = 1'b0;
        wait_cnt(0, rd_stat_cnt + 1, 50, "poll_after_tx");
        chk("tx_ready_single_pulse", tx_rdy_cnt - t0, 1);

        // busy transmitter blocks writes for three poll periods
        tx_busy = 1'b1; tx_data = 8'($urandom); tx_valid = 1'b1; exp_tx.push_back(tx_data);
        w0 = wr_tx_cnt;
        wait_cnt(0, rd_stat_cnt + 3, 200, "busy_polls");
        chk("no_write_while_busy", wr_tx_cnt - w0, 0);
        tx_busy = 1'b0;
        wait_cnt(2, w0 + 1, 100, "tx_after_busy");
        tx_valid = 1'b0;

        // interrupt two cycles into WAIT, status 0x06
        wait_cnt(0, rd_stat_cnt + 1, 50, "poll_before_inter");
        @(posedge clk); #1;
        inter = 1'b1; err_bits = 3'b011; ep = err_pulse_cnt;
        seen = 1'b0; lat = 0;
        for (int k = 1; k <= 4 && !seen; k++) begin
            @(negedge clk);
            if (bus.ce && !bus.we && bus.adr == 2'd1) begin
                seen = 1'b1;
                lat = k;
            end
        end
        chk("inter_latency_le2", seen && lat <= 2, 1);
        @(posedge clk); #1;
        inter = 1'b0; err_bits = 3'b000;
        repeat (4) @(posedge clk);
        #1 chk("err_pulse_once", err_pulse_cnt - ep, 1);

        // stalled consumer: exactly one rx read, tx still served
        sink_level = 1'b0;
        @(posedge clk); #1;
        r0 = rd_rx_cnt; h0 = rx_hs_cnt;
        b = 8'($urandom); rx_buf = b; exp_rx.push_back(b); rx_avail = 1'b1;
        wait_cnt(1, r0 + 1, 100, "stall_first_read");
        b = 8'($urandom); rx_buf = b; exp_rx.push_back(b);
        tx_data = 8'($urandom); tx_valid = 1'b1; exp_tx.push_back(tx_data);
        wait_cnt(2, wr_tx_cnt + 1, 100, "tx_during_stall");
        tx_valid = 1'b0;
        wait_cnt(0, rd_stat_cnt + 4, 200, "stall_polls");
        chk("stalled_single_rx_read", rd_rx_cnt - r0, 1);
        sink_level = 1'b1;
        wait_cnt(1, r0 + 2, 100, "rx_read_after_stall");
        rx_avail = 1'b0;
        wait_cnt(3, h0 + 2, 100, "rx_hs_after_stall");

        // cfg_req together with inter in WAIT: reconfiguration wins
        wait_cnt(0, rd_stat_cnt + 1, 50, "poll_before_cfg_req");
        cfg_req = 1'b1; inter = 1'b1;
        @(posedge clk); #1;
        cfg_req = 1'b0; inter = 1'b0;
        cfg_seq("recfg");

        // randomized mix of rx bytes, tx bytes and error reports
        sink_rand = 1'b1;
        for (int it = 0; it < 14; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    b = 8'($urandom); rx_buf = b; exp_rx.push_back(b); rx_avail = 1'b1;
                    wait_cnt(1, rd_rx_cnt + 1, 300, "rand_rx_read");
                    rx_avail = 1'b0;
                end
                1: begin
                    tx_busy = 1'($urandom_range(0, 1));
                    tx_data = 8'($urandom); tx_valid = 1'b1; exp_tx.push_back(tx_data);
                    w0 = wr_tx_cnt;
                    if (tx_busy) begin
                        wait_cnt(0, rd_stat_cnt + int'($urandom_range(1, 3)), 200, "rand_busy_polls");
                        chk("rand_no_write_while_busy", wr_tx_cnt - w0, 0);
                        tx_busy = 1'b0;
                    end
                    wait_cnt(2, w0 + 1, 200, "rand_tx_write");
                    tx_valid = 1'b0;
                end
                default: begin
                    err_bits = 3'($urandom_range(1, 7));
                    wait_cnt(0, rd_stat_cnt + 1, 100, "rand_err_poll");
                    err_bits = 3'b000;
                end
            endcase
        end
        sink_rand = 1'b0; sink_level = 1'b1;
        wait_cnt(3, rx_hs_cnt + exp_rx.size(), 100, "rx_drain");

        // reset in the middle of a tx write
        tx_data = 8'($urandom); tx_valid = 1'b1; exp_tx.push_back(tx_data);
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (bus.ce && bus.we && bus.adr == 2'd0) seen = 1'b1;
        end
        chk("wr_tx_seen_before_reset", seen, 1);
        #1 arst = 1'b1; mon_en = 1'b0;
        #1;
        chk("abort_ce", bus.ce, 0);
        chk("abort_dat_oe", bus.dat_oe, 0);
        chk("abort_tx_ready", tx_ready, 0);
        tx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 arst = 1'b0; mon_en = 1'b1;
        cfg_seq("restart");

        repeat (20) @(posedge clk);
        #1;
        chk("exp_rx_empty", exp_rx.size(), 0);
        chk("exp_tx_empty", exp_tx.size(), 0);
        chk("exp_err_empty", exp_err_cyc.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
